wb_slave_mux: RTL and testbench

//   Wishbone cycle controller between the bridge's single FPGA-side Wishbone port and up to
//   NUM_SLV FPGA peripherals. Decodes the target from address bits, registers and issues the

---
 rtl/wb_mux_pkg.sv | 22 ++
 rtl/wb_timeout_ctr.sv | 35 +++
 rtl/wb_slave_mux.sv | 188 ++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_pkg.sv
// Shared types and width helpers for the Wishbone slave multiplexer.
// Holds the controller state encoding and the default read data returned on failed cycles.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mux_state_e;

    localparam logic [31:0] DEF_ERR_DATA = 32'hBAD0_BAD0;

    // A single slave still needs a 1-bit index register even though no address bits decode it.
    function automatic int sel_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

    function automatic int ctr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-cycle wait counter for the slave multiplexer.
// Flags expiry in the cycle where the count reaches TIMEOUT-1 while enabled.
module wb_timeout_ctr
    import wb_mux_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Wait counter: restarts on clear, advances while enabled and parks at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone cycle controller: decodes a slave index from the bridge address, issues one
// registered cycle to that slave and returns a single-cycle ack/err with read data.
module wb_slave_mux
    import wb_mux_pkg::*;
#(
    parameter int          NUM_SLV  = 4,
    parameter int          ADR_W    = 17,
    parameter int          SEL_LSB  = 14,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST_N,
    input  logic [ADR_W-1:0]      m_adr,
    input  logic                  m_cyc,
    input  logic                  m_stb,
    input  logic                  m_we,
    input  logic [3:0]            m_sel,
    input  logic [31:0]           m_dat_w,
    output logic [31:0]           m_dat_r,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [NUM_SLV-1:0]    s_cyc,
    output logic [NUM_SLV-1:0]    s_stb,
    output logic [ADR_W-1:0]      s_adr,
    output logic                  s_we,
    output logic [3:0]            s_sel,
    output logic [31:0]           s_dat_w,
    input  logic [32*NUM_SLV-1:0] s_dat_r,
    input  logic [NUM_SLV-1:0]    s_ack,
    input  logic [NUM_SLV-1:0]    s_err,
    output logic [7:0]            to_count
);

    localparam int               SEL_W     = sel_width(NUM_SLV);
    localparam logic [SEL_W:0]   NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);

    mux_state_e         state_r, state_s;
    logic [SEL_W-1:0]   idx_r, idx_s;
    logic [SEL_W-1:0]   field_s;
    logic               dec_ok_s;
    logic [NUM_SLV-1:0] act_r, act_s;
    logic [ADR_W-1:0]   adr_s;
    logic               we_s;
    logic [3:0]         sel_s;
    logic [31:0]        dat_w_s;
    logic [31:0]        dat_r_s;
    logic               ack_s, err_s;
    logic [7:0]         to_cnt_s;
    logic               sel_ack_s, sel_err_s;
    logic [31:0]        sel_dat_s;
    logic               ctr_clear_s, ctr_en_s, expire_s;

    assign field_s  = (NUM_SLV > 1) ? m_adr[SEL_LSB +: SEL_W] : '0;
    assign dec_ok_s = ({1'b0, field_s} < NUM_SLV_L);
    assign s_cyc    = act_r;
    assign s_stb    = act_r;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (WB_CLK),
        .rst_n  (WB_RST_N),
        .clear  (ctr_clear_s),
        .enable (ctr_en_s),
        .expire (expire_s)
    );

    // Route only the addressed slave's response and data; all other slaves are masked off
    always_comb begin
        sel_ack_s = 1'b0;
        sel_err_s = 1'b0;
        sel_dat_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_ack_s = sel_ack_s | (s_ack[i] & (idx_r == SEL_W'(i)));
            sel_err_s = sel_err_s | (s_err[i] & (idx_r == SEL_W'(i)));
            sel_dat_s = sel_dat_s | (s_dat_r[32*i +: 32] & {32{idx_r == SEL_W'(i)}});
        end
    end

    // Next-state and next-output logic; in BUSY err beats ack, ack beats timeout, timeout beats abort
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        act_s       = act_r;
        adr_s       = s_adr;
        we_s        = s_we;
        sel_s       = s_sel;
        dat_w_s     = s_dat_w;
        dat_r_s     = m_dat_r;
        ack_s       = 1'b0;
        err_s       = 1'b0;
        to_cnt_s    = to_count;
        ctr_clear_s = 1'b0;
        ctr_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    adr_s   = m_adr;
                    we_s    = m_we;
                    sel_s   = m_sel;
                    dat_w_s = m_dat_w;
                    idx_s   = field_s;
                    if (dec_ok_s) begin
                        state_s     = BUSY;
                        act_s       = NUM_SLV'(1'b1) << field_s;
                        ctr_clear_s = 1'b1;
                    end else begin
                        state_s = RESP;
                        err_s   = 1'b1;
                        dat_r_s = ERR_DATA;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                ctr_en_s = 1'b1;
                if (sel_err_s) begin
                    state_s = RESP;
                    act_s   = '0;
                    err_s   = 1'b1;
                    dat_r_s = sel_dat_s;
                end else if (sel_ack_s) begin
                    state_s = RESP;
                    act_s   = '0;
                    ack_s   = 1'b1;
                    dat_r_s = sel_dat_s;
                end else if (expire_s) begin
                    state_s  = RESP;
                    act_s    = '0;
                    err_s    = 1'b1;
                    dat_r_s  = ERR_DATA;
                    to_cnt_s = (to_count == 8'hFF) ? to_count : to_count + 8'd1;
                end else if (!m_cyc) begin
                    state_s = IDLE;
                    act_s   = '0;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                act_s   = '0;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered datapath and outputs; reset clears everything so an in-flight cycle vanishes
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            idx_r    <= '0;
            act_r    <= '0;
            s_adr    <= '0;
            s_we     <= 1'b0;
            s_sel    <= 4'h0;
            s_dat_w  <= 32'h0000_0000;
            m_dat_r  <= 32'h0000_0000;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
            to_count <= 8'h00;
        end else begin
            idx_r    <= idx_s;
            act_r    <= act_s;
            s_adr    <= adr_s;
            s_we     <= we_s;
            s_sel    <= sel_s;
            s_dat_w  <= dat_w_s;
            m_dat_r  <= dat_r_s;
            m_ack    <= ack_s;
            m_err    <= err_s;
            to_count <= to_cnt_s;
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Self-checking bench for wb_slave_mux (3 slaves, short timeout): directed vector table,
// a reset/abort sequence, randomized transactions against a transaction-level model.
module tb_wb_slave_mux;

    localparam int          NUM_SLV  = 3;
    localparam int          ADR_W    = 17;
    localparam int          SEL_LSB  = 14;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;
    localparam int          NEVER    = 1 << 30;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b1;
    logic [ADR_W-1:0]       m_adr = '0;
    logic                   m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [3:0]             m_sel = 4'h0;
    logic [31:0]            m_dat_w = 32'h0;
    logic [31:0]            m_dat_r;
    logic                   m_ack, m_err;
    logic [NUM_SLV-1:0]     s_cyc, s_stb;
    logic [ADR_W-1:0]       s_adr;
    logic                   s_we;
    logic [3:0]             s_sel;
    logic [31:0]            s_dat_w;
    logic [32*NUM_SLV-1:0]  s_dat_r = '0;
    logic [NUM_SLV-1:0]     s_ack = '0, s_err = '0;
    logic [7:0]             to_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tocnt    = 0;
    logic [31:0] last_dat = 32'h0;

    // kind: 0 silent, 1 ack, 2 err, 3 ack+err; exp_resp: 0 none, 1 ack, 2 err; exp_cyc -1 = decode error
    typedef struct {
        logic [ADR_W-1:0] adr;
        logic             we;
        logic [3:0]       sel;
        logic [31:0]      wdat;
        logic [31:0]      rdat;
        int               kind;
        int               wait_c;
        bit               noise;
        int               abort_at;
        int               exp_resp;
        int               exp_cyc;
        logic [31:0]      exp_dat;
        bit               exp_to;
    } vec_t;

    vec_t vecs[$];

    wb_slave_mux #(
        .NUM_SLV  (NUM_SLV),
        .ADR_W    (ADR_W),
        .SEL_LSB  (SEL_LSB),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .WB_CLK   (clk),
        .WB_RST_N (rst_n),
        .m_adr    (m_adr),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_sel    (m_sel),
        .m_dat_w  (m_dat_w),
        .m_dat_r  (m_dat_r),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_adr    (s_adr),
        .s_we     (s_we),
        .s_sel    (s_sel),
        .s_dat_w  (s_dat_w),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .to_count (to_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [ADR_W-1:0] adr, input logic we, input logic [3:0] sel,
                                input logic [31:0] wdat, input logic [31:0] rdat, input int kind,
                                input int wait_c, input bit noise, input int abort_at,
                                input int exp_resp, input int exp_cyc, input logic [31:0] exp_dat,
                                input bit exp_to);
        vec_t v;
        v.adr = adr; v.we = we; v.sel = sel; v.wdat = wdat; v.rdat = rdat; v.kind = kind;
        v.wait_c = wait_c; v.noise = noise; v.abort_at = abort_at; v.exp_resp = exp_resp;
        v.exp_cyc = exp_cyc; v.exp_dat = exp_dat; v.exp_to = exp_to;
        return v;
    endfunction

    // Reference model: earliest event in the BUSY phase decides; same-cycle ties go err > ack > timeout > abort
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   idx, t_resp, t_ab, t;
        r = v;
        r.exp_to = 1'b0;
        idx = int'(v.adr[SEL_LSB +: 2]);
        if (idx >= NUM_SLV) begin
            r.exp_resp = 2; r.exp_cyc = -1; r.exp_dat = ERR_DATA;
            return r;
        end
        t_resp = (v.kind != 0) ? v.wait_c : NEVER;
        t_ab   = (v.abort_at >= 0) ? v.abort_at : NEVER;
        t = TIMEOUT - 1;
        if (t_resp < t) t = t_resp;
        if (t_ab < t) t = t_ab;
        r.exp_cyc = t;
        if (t_resp == t) begin
            r.exp_resp = (v.kind >= 2) ? 2 : 1; r.exp_dat = v.rdat;
        end else if (t == TIMEOUT - 1) begin
            r.exp_resp = 2; r.exp_dat = ERR_DATA; r.exp_to = 1'b1;
        end else begin
            r.exp_resp = 0; r.exp_dat = 32'h0;
        end
        return r;
    endfunction

    // Runs one master transaction starting from IDLE, #1 after a rising edge
    task automatic run_txn(input vec_t v);
        int                 idx, oth;
        logic [NUM_SLV-1:0] oh;
        idx = int'(v.adr[SEL_LSB +: 2]);
        oth = (idx + 1) % NUM_SLV;
        oh  = (idx < NUM_SLV) ? NUM_SLV'(1 << idx) : '0;
        m_adr = v.adr; m_we = v.we; m_sel = v.sel; m_dat_w = v.wdat;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        chk("s_adr", 32'(s_adr), 32'(v.adr));
        chk("s_we", 32'(s_we), 32'(v.we));
        chk("s_sel", 32'(s_sel), 32'(v.sel));
        chk("s_dat_w", s_dat_w, v.wdat);
        chk("s_stb_issue", 32'(s_stb), 32'(oh));
        chk("s_cyc_issue", 32'(s_cyc), 32'(oh));
        if (v.exp_cyc >= 0) begin
            for (int k = 0; k <= v.exp_cyc; k++) begin
                for (int i = 0; i < NUM_SLV; i++) s_dat_r[32*i +: 32] = $urandom;
                s_dat_r[32*idx +: 32] = v.rdat;
                s_ack = '0; s_err = '0;
                if (v.noise) begin s_ack[oth] = 1'b1; s_err[oth] = 1'b1; end
                if (k == v.wait_c) begin
                    s_ack[idx] = (v.kind == 1) || (v.kind == 3);
                    s_err[idx] = (v.kind >= 2);
                end
                if (k == v.abort_at) begin m_cyc = 1'b0; m_stb = 1'b0; end
                @(posedge clk); #1;
                s_ack = '0; s_err = '0;
                if (k < v.exp_cyc) begin
                    chk("s_stb_busy", 32'(s_stb), 32'(oh));
                    chk("no_resp_busy", 32'({m_ack, m_err}), 32'h0);
                end
            end
        end
        chk("s_stb_after", 32'(s_stb), 32'h0);
        chk("s_cyc_after", 32'(s_cyc), 32'h0);
        chk("m_ack", 32'(m_ack), 32'(v.exp_resp == 1));
        chk("m_err", 32'(m_err), 32'(v.exp_resp == 2));
        if (v.exp_resp != 0) last_dat = v.exp_dat;
        if (v.exp_to && tocnt < 255) tocnt++;
        chk("m_dat_r", m_dat_r, last_dat);
        chk("to_count", 32'(to_count), 32'(tocnt));
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        chk("resp_one_cycle", 32'({m_ack, m_err}), 32'h0);
        chk("m_dat_r_hold", m_dat_r, last_dat);
    endtask

    initial begin
        vecs.push_back(mk(17'h0_8004, 1'b0, 4'hF, 32'h0,         32'h1234_5678, 1, 0,  1'b0, -1, 1, 0,  32'h1234_5678, 1'b0));
        vecs.push_back(mk(17'h0_4010, 1'b1, 4'h6, 32'hA5A5_1234, 32'h0000_00FF, 1, 5,  1'b0, -1, 1, 5,  32'h0000_00FF, 1'b0));
        vecs.push_back(mk(17'h0_8020, 1'b0, 4'hF, 32'h0,         32'h7777_7777, 0, 0,  1'b0, -1, 2, 15, ERR_DATA,      1'b1));
        vecs.push_back(mk(17'h0_C000, 1'b0, 4'hF, 32'h0,         32'h0,         0, 0,  1'b0, -1, 2, -1, ERR_DATA,      1'b0));
        vecs.push_back(mk(17'h1_C0F0, 1'b1, 4'h3, 32'h0BAD_F00D, 32'h0,         0, 0,  1'b0, -1, 2, -1, ERR_DATA,      1'b0));
        vecs.push_back(mk(17'h0_0008, 1'b0, 4'hF, 32'h0,         32'h5555_AAAA, 3, 2,  1'b0, -1, 2, 2,  32'h5555_AAAA, 1'b0));
        vecs.push_back(mk(17'h0_4000, 1'b0, 4'hF, 32'h0,         32'h0F0F_0F0F, 1, 4,  1'b1, -1, 1, 4,  32'h0F0F_0F0F, 1'b0));
        vecs.push_back(mk(17'h0_0100, 1'b0, 4'hF, 32'h0,         32'h1111_1111, 0, 0,  1'b0, 3,  0, 3,  32'h0,         1'b0));
        vecs.push_back(mk(17'h0_8ABC, 1'b0, 4'hF, 32'h0,         32'h0ACE_0ACE, 1, 15, 1'b0, -1, 1, 15, 32'h0ACE_0ACE, 1'b0));
        vecs.push_back(mk(17'h1_4444, 1'b1, 4'h8, 32'h1357_9BDF, 32'hDEAD_BEEF, 2, 7,  1'b0, -1, 2, 7,  32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(17'h0_0000, 1'b0, 4'hF, 32'h0,         32'h2222_2222, 1, 16, 1'b0, -1, 2, 15, ERR_DATA,      1'b1));

        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_m_resp", 32'({m_ack, m_err}), 32'h0);
        chk("rst_m_dat_r", m_dat_r, 32'h0);
        chk("rst_to_count", 32'(to_count), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Abort by dropping m_cyc, then reset in the middle of a later cycle
        run_txn(mk(17'h0_4000, 1'b0, 4'hF, 32'h0, 32'h3333_3333, 0, 0, 1'b0, 2, 0, 2, 32'h0, 1'b0));
        m_adr = 17'h0_8000; m_we = 1'b1; m_sel = 4'hF; m_dat_w = 32'h1111_2222;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_s_stb", 32'(s_stb), 32'h4);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tocnt = 0; last_dat = 32'h0;
        chk("midrst_s_stb", 32'(s_stb), 32'h0);
        chk("midrst_s_cyc", 32'(s_cyc), 32'h0);
        chk("midrst_s_adr", 32'(s_adr), 32'h0);
        chk("midrst_s_we_sel", 32'({s_we, s_sel}), 32'h0);
        chk("midrst_s_dat_w", s_dat_w, 32'h0);
        chk("midrst_m_resp", 32'({m_ack, m_err}), 32'h0);
        chk("midrst_m_dat_r", m_dat_r, 32'h0);
        chk("midrst_to_count", 32'(to_count), 32'h0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_resp", 32'({m_ack, m_err}), 32'h0);
        run_txn(mk(17'h0_8010, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0, -1, 1, 1, 32'hCAFE_F00D, 1'b0));

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.adr      = 17'($urandom);
            v.adr[15:14] = 2'($urandom_range(0, 3));
            v.we       = 1'($urandom);
            v.sel      = 4'($urandom);
            v.wdat     = $urandom;
            v.rdat     = $urandom;
            v.kind     = $urandom_range(0, 3);
            v.wait_c   = $urandom_range(0, 20);
            v.noise    = 1'($urandom);
            v.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1;
            run_txn(predict(v));
        end

        // Drive the timeout counter into saturation
        for (int n = 0; n < 260; n++) begin
            run_txn(predict(mk(17'h0_0040, 1'b0, 4'hF, 32'h0, 32'h0, 0, 0, 1'b0, -1, 0, 0, 32'h0, 1'b0)));
        end
        chk("to_count_sat", 32'(to_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
